sha256_msg_padder: RTL and testbench

SHA256_MSG_PADDER -- requirements
Module: sha256_msg_padder

---
 rtl/sha256_msg_padder.sv | 143 ++++++++++++++
 tb/tb_sha256_msg_padder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks and appends the
// 0x80 marker, zero fill and the 64-bit big-endian bit length.
module sha256_msg_padder #(
   parameter int unsigned LEN_W            = 16,
   parameter int unsigned DOUBLE_LEN_CHECK = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_valid,
   output logic         i_ready,
   input  logic [7:0]   i_data,
   input  logic         i_last,
   output logic         o_blk_valid,
   input  logic         o_blk_ready,
   output logic [511:0] o_blk,
   output logic         o_blk_first,
   output logic         o_blk_last,
   output logic         o_err
);

   typedef enum logic [1:0] {StFill, StPad, StLen, StEmit} state_e;

   state_e             state_q, state_d;
   logic [5:0]         idx_q, idx_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic               first_pend_q, first_pend_d;
   logic               len_pend_q, len_pend_d;
   logic               pad_pend_q, pad_pend_d;
   logic               last_q, last_d;
   logic               err_q, err_d;
   logic [511:0]       blk_q, blk_d;
   logic               accept;
   logic [63:0]        len_bits;

   assign i_ready     = (state_q == StFill);
   assign accept      = i_valid & i_ready;
   assign len_bits    = 64'(cnt_q) << 3;
   assign o_blk_valid = (state_q == StEmit);
   assign o_blk       = blk_q;
   assign o_blk_first = first_pend_q;
   assign o_blk_last  = last_q;
   assign o_err       = err_q;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      first_pend_d = first_pend_q;
      len_pend_d   = len_pend_q;
      pad_pend_d   = pad_pend_q;
      last_d       = last_q;
      err_d        = err_q;
      blk_d        = blk_q;
      unique case (state_q)
         StFill: begin
            if (accept) begin
               // byte k lives at bits [511-8k -: 8], i.e. base (63-k)*8
               blk_d[{~idx_q, 3'b000} +: 8] = i_data;
               idx_d = idx_q + 6'd1;
               cnt_d = cnt_q + 1'b1;
               if ((DOUBLE_LEN_CHECK != 0) && (&cnt_q)) err_d = 1'b1;
               if (idx_q == 6'd63) begin
                  state_d    = StEmit;
                  last_d     = 1'b0;
                  pad_pend_d = i_last;
               end else if (i_last) begin
                  state_d = StPad;
               end
            end
         end
         StPad: begin
            for (int unsigned k = 0; k < 64; k++) begin
               if (6'(k) == idx_q) begin
                  blk_d[511 - 8*k -: 8] = 8'h80;
               end else if (6'(k) > idx_q) begin
                  blk_d[511 - 8*k -: 8] = 8'h00;
               end
            end
            if (idx_q <= 6'd55) begin
               blk_d[63:0] = len_bits;
               last_d      = 1'b1;
            end else begin
               len_pend_d = 1'b1;
               last_d     = 1'b0;
            end
            state_d = StEmit;
         end
         StLen: begin
            blk_d   = {448'd0, len_bits};
            last_d  = 1'b1;
            state_d = StEmit;
         end
         StEmit: begin
            if (o_blk_ready) begin
               first_pend_d = 1'b0;
               if (last_q) begin
                  cnt_d        = '0;
                  idx_d        = '0;
                  len_pend_d   = 1'b0;
                  pad_pend_d   = 1'b0;
                  first_pend_d = 1'b1;
                  last_d       = 1'b0;
                  state_d      = StFill;
               end else if (len_pend_q) begin
                  len_pend_d = 1'b0;
                  state_d    = StLen;
               end else if (pad_pend_q) begin
                  pad_pend_d = 1'b0;
                  state_d    = StPad;
               end else begin
                  state_d = StFill;
               end
            end
         end
         default: state_d = StFill;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StFill;
         idx_q        <= '0;
         cnt_q        <= '0;
         first_pend_q <= 1'b1;
         len_pend_q   <= 1'b0;
         pad_pend_q   <= 1'b0;
         last_q       <= 1'b0;
         err_q        <= 1'b0;
         blk_q        <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         first_pend_q <= first_pend_d;
         len_pend_q   <= len_pend_d;
         pad_pend_q   <= pad_pend_d;
         last_q       <= last_d;
         err_q        <= err_d;
         blk_q        <= blk_d;
      end
   end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: padded blocks are compared against a byte-queue
// model of SHA-256 padding, with random stalls, gaps and message lengths.
module tb_sha256_msg_padder;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_valid, i_ready, i_last;
   logic [7:0]   i_data;
   logic         o_blk_valid, o_blk_ready, o_blk_first, o_blk_last, o_err;
   logic [511:0] o_blk;

   logic         v7, rdy7, l7, bv7, br7, bf7, bl7, err7;
   logic [7:0]   d7;
   logic [511:0] blk7;

   int checks = 0;
   int errors = 0;
   bit rand_rdy = 1'b0;
   bit gap_en   = 1'b0;

   logic [7:0]   msg_q[$];
   logic [511:0] exp_blk[$];
   logic         exp_first[$], exp_last[$];
   logic [511:0] got_blk[$];
   logic         got_first[$], got_last[$];

   always #5 clk = ~clk;

   sha256_msg_padder #(.LEN_W(16), .DOUBLE_LEN_CHECK(1)) dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
      .i_last(i_last), .o_blk_valid(o_blk_valid), .o_blk_ready(o_blk_ready), .o_blk(o_blk),
      .o_blk_first(o_blk_first), .o_blk_last(o_blk_last), .o_err(o_err)
   );

   sha256_msg_padder #(.LEN_W(7), .DOUBLE_LEN_CHECK(1)) dut7 (
      .clk(clk), .rst_n(rst_n), .i_valid(v7), .i_ready(rdy7), .i_data(d7),
      .i_last(l7), .o_blk_valid(bv7), .o_blk_ready(br7), .o_blk(blk7),
      .o_blk_first(bf7), .o_blk_last(bl7), .o_err(err7)
   );

   task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Reference: append 0x80, zero-fill to 56 mod 64, append 64-bit bit length.
   task automatic build_expected();
      logic [7:0]   p[$];
      logic [63:0]  bits;
      logic [511:0] b;
      int           nb;
      p = msg_q;
      p.push_back(8'h80);
      while ((p.size() % 64) != 56) p.push_back(8'h00);
      bits = 64'(msg_q.size()) * 64'd8;
      for (int s = 7; s >= 0; s--) p.push_back(8'(bits >> (8*s)));
      nb = p.size() / 64;
      exp_blk.delete(); exp_first.delete(); exp_last.delete();
      for (int j = 0; j < nb; j++) begin
         for (int k = 0; k < 64; k++) b[511 - 8*k -: 8] = p[j*64 + k];
         exp_blk.push_back(b);
         exp_first.push_back(j == 0);
         exp_last.push_back(j == nb - 1);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && o_blk_valid && o_blk_ready) begin
         got_blk.push_back(o_blk);
         got_first.push_back(o_blk_first);
         got_last.push_back(o_blk_last);
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_rdy) o_blk_ready = ($urandom_range(0, 2) != 0);
      end
   end

   task automatic clear_got();
      got_blk.delete(); got_first.delete(); got_last.delete();
   endtask

   task automatic send_msg(input bit with_last, input bit chk_lat);
      int i = 0;
      int guard = 0;
      while (i < msg_q.size() && guard < 5000) begin
         @(posedge clk); #1;
         if (gap_en && $urandom_range(0, 3) == 0) begin
            i_valid = 1'b0;
            i_last  = 1'($urandom_range(0, 1));
            i_data  = 8'($urandom);
         end else begin
            i_valid = 1'b1;
            i_data  = msg_q[i];
            i_last  = with_last && (i == msg_q.size() - 1);
         end
         @(negedge clk);
         if (i_valid && i_ready) i++;
         guard++;
      end
      if (guard >= 5000) check_eq("send_timeout", 512'(i), 512'(msg_q.size()));
      @(posedge clk); #1;
      i_valid = 1'b0;
      i_last  = 1'b0;
      if (chk_lat) begin
         @(negedge clk);
         check_eq("pad_cycle_valid", 512'(o_blk_valid), 512'd0);
         @(negedge clk);
         check_eq("latency_valid", 512'(o_blk_valid), 512'd1);
      end
   endtask

   task automatic wait_blocks(input int n);
      int t = 0;
      while (got_blk.size() < n && t < 3000) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      check_eq("blk_count", 512'(got_blk.size()), 512'(n));
   endtask

   task automatic compare_blocks(input string tag);
      int n;
      n = (got_blk.size() < exp_blk.size()) ? got_blk.size() : exp_blk.size();
      for (int j = 0; j < n; j++) begin
         check_eq({tag, "_blk"}, got_blk[j], exp_blk[j]);
         check_eq({tag, "_first"}, 512'(got_first[j]), 512'(exp_first[j]));
         check_eq({tag, "_last"}, 512'(got_last[j]), 512'(exp_last[j]));
      end
   endtask

   task automatic run_msg(input string tag, input bit chk_lat);
      build_expected();
      clear_got();
      send_msg(1'b1, chk_lat);
      wait_blocks(exp_blk.size());
      compare_blocks(tag);
   endtask

   task automatic set_abc();
      msg_q.delete();
      msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
   endtask

   initial begin
      logic [511:0] hold_blk;
      logic         hold_first, hold_last;
      int           t;
      int           n7, g7;
      rst_n = 1'b0; i_valid = 1'b0; i_last = 1'b0; i_data = 8'h00; o_blk_ready = 1'b1;
      v7 = 1'b0; l7 = 1'b0; d7 = 8'h00; br7 = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("rst_blk", o_blk, 512'd0);
      check_eq("rst_valid", 512'(o_blk_valid), 512'd0);
      check_eq("rst_last", 512'(o_blk_last), 512'd0);
      check_eq("rst_first", 512'(o_blk_first), 512'd1);
      check_eq("rst_err", 512'(o_err), 512'd0);
      check_eq("rst_iready", 512'(i_ready), 512'd1);
      @(posedge clk); #1 rst_n = 1'b1;

      set_abc();
      run_msg("abc", 1'b1);

      rand_rdy = 1'b1;
      gap_en   = 1'b1;
      msg_q.delete();
      for (int k = 0; k < 55; k++) msg_q.push_back(8'h00);
      run_msg("len55", 1'b0);
      msg_q.delete();
      for (int k = 0; k < 56; k++) msg_q.push_back(8'($urandom));
      run_msg("len56", 1'b0);
      msg_q.delete();
      for (int k = 0; k < 64; k++) msg_q.push_back(8'(k));
      run_msg("len64", 1'b0);

      // Stall during EMIT while junk is offered on the input.
      rand_rdy = 1'b0;
      gap_en   = 1'b0;
      @(posedge clk); #1 o_blk_ready = 1'b0;
      set_abc();
      build_expected();
      clear_got();
      send_msg(1'b1, 1'b0);
      t = 0;
      while (!o_blk_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      check_eq("stall_valid", 512'(o_blk_valid), 512'd1);
      hold_blk = o_blk; hold_first = o_blk_first; hold_last = o_blk_last;
      @(posedge clk); #1;
      i_valid = 1'b1; i_data = 8'hFF; i_last = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check_eq("stall_blk", o_blk, hold_blk);
         check_eq("stall_first", 512'(o_blk_first), 512'(hold_first));
         check_eq("stall_last", 512'(o_blk_last), 512'(hold_last));
         check_eq("stall_iready", 512'(i_ready), 512'd0);
      end
      @(posedge clk); #1;
      o_blk_ready = 1'b1; i_valid = 1'b0; i_last = 1'b0;
      wait_blocks(1);
      compare_blocks("stall");
      set_abc();
      run_msg("b2b", 1'b0);

      // Reset in the middle of a message.
      msg_q.delete();
      for (int k = 0; k < 30; k++) msg_q.push_back(8'($urandom));
      send_msg(1'b0, 1'b0);
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      check_eq("midrst_first", 512'(o_blk_first), 512'd1);
      check_eq("midrst_blk", o_blk, 512'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      set_abc();
      run_msg("after_rst", 1'b1);

      rand_rdy = 1'b1;
      gap_en   = 1'b1;
      for (int m = 0; m < 20; m++) begin
         int len;
         len = $urandom_range(1, 150);
         msg_q.delete();
         for (int k = 0; k < len; k++) msg_q.push_back(8'($urandom));
         run_msg("rand", 1'b0);
      end
      check_eq("no_err", 512'(o_err), 512'd0);

      // 128 bytes overflow a 7-bit byte counter.
      n7 = 0;
      g7 = 0;
      while (n7 < 128 && g7 < 3000) begin
         @(posedge clk); #1;
         v7 = 1'b1; d7 = 8'(n7); l7 = (n7 == 127);
         @(negedge clk);
         if (rdy7) n7++;
         g7++;
      end
      @(posedge clk); #1 v7 = 1'b0; l7 = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("len7_err", 512'(err7), 512'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
